// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: DEPTH-entry FIFO of {instr, pc, pc+8}.
// Optional zero-latency pass-through on an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         InstrIn,
  input  logic [WIDTH-1:0]         PCIn,
  input  logic [WIDTH-1:0]         PCPlus8In,
  input  logic                     InValid,
  output logic                     InReady,
  output logic [WIDTH-1:0]         InstrOut,
  output logic [WIDTH-1:0]         PCOut,
  output logic [WIDTH-1:0]         PCPlus8Out,
  output logic                     OutValid,
  input  logic                     OutReady,
  input  logic                     Flush,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc8;
  } entry_t;

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // ready never depends on the other side's valid or ready in the same cycle.

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t          in_entry;
  entry_t          head;
  logic            empty;
  logic            full;
  logic            in_ready;
  logic            stored_valid;
  logic            bypass_valid;
  logic            push_en;
  logic            pop_en;

  assign in_entry = '{instr: InstrIn, pc: PCIn, pc8: PCPlus8In};
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  // Combinational outputs are gated by reset so they read 0 while it is held.
  assign in_ready     = reset && !full && !Flush;
  assign stored_valid = reset && !empty && !Flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_valid = reset && empty && InValid && !Flush;
`else
  assign bypass_valid = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never touches storage.
  assign push_en = InValid && in_ready && !(bypass_valid && OutReady);
  assign pop_en  = stored_valid && OutReady;

  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem_q[rd_ptr_q];
    end else if (bypass_valid) begin
      head = in_entry;
    end
  end

  assign InReady    = in_ready;
  assign OutValid   = stored_valid || bypass_valid;
  assign InstrOut   = head.instr;
  assign PCOut      = head.pc;
  assign PCPlus8Out = head.pc8;
  assign Count      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (push_en) mem_d[wr_ptr_q] = in_entry;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
// Expectations follow FETCH_QUEUE_BYPASS_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  instr_in = '0, pc_in = '0, pc8_in = '0;
  logic          iv = 1'b0, ordy = 1'b0, fl = 1'b0;
  logic          in_ready, out_valid;
  logic [W-1:0]  instr_out, pc_out, pc8_out;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3*W-1:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .InstrIn(instr_in), .PCIn(pc_in), .PCPlus8In(pc8_in),
    .InValid(iv), .InReady(in_ready),
    .InstrOut(instr_out), .PCOut(pc_out), .PCPlus8Out(pc8_out),
    .OutValid(out_valid), .OutReady(ordy), .Flush(fl), .Count(count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic exp_in_ready();
    return (exp_q.size() != DEPTH) && !fl;
  endfunction

  function automatic logic exp_out_valid();
    return ((exp_q.size() != 0) && !fl) || (BYP && exp_q.size() == 0 && iv && !fl);
  endfunction

  function automatic logic [3*W-1:0] exp_head();
    if (exp_q.size() != 0) return exp_q[0];
    if (BYP && iv && !fl) return {instr_in, pc_in, pc8_in};
    return '0;
  endfunction

  task automatic model_step();
    bit do_push, do_pop;
    if (fl) begin
      exp_q.delete();
    end else if (!(BYP && exp_q.size() == 0 && iv && ordy)) begin
      do_pop  = (exp_q.size() != 0) && ordy;
      do_push = iv && (exp_q.size() != DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({instr_in, pc_in, pc8_in});
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] pc);
    iv       = v;
    pc_in    = pc;
    pc8_in   = pc + 32'd8;
    instr_in = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_tests++; if ({instr_out, pc_out, pc8_out} !== '0) begin n_fail++; $display("FAIL rst_head: got %h expected 0", {instr_out, pc_out, pc8_out}); end
    @(posedge clock); #1;
    reset = 1'b1;
    #4;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_fill();
    ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'(i * 4));
      #4;
      n_tests++; if (in_ready !== 1'b1 || count !== CW'(i)) begin n_fail++; $display("FAIL fill_%0d: got ready=%b count=%0d expected ready=1 count=%0d", i, in_ready, count, i); end
      advance();
    end
    set_in(1'b1, 32'h10);
    #4;
    n_tests++; if (count !== CW'(4) || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got count=%0d ready=%b expected count=4 ready=0", count, in_ready); end
    advance();
    set_in(1'b0, '0);
    #4;
    n_tests++; if (count !== CW'(4) || pc_out !== 32'h0) begin n_fail++; $display("FAIL fill_fifth_ignored: got count=%0d pc=%h expected count=4 pc=0", count, pc_out); end
  endtask

  task automatic test_drain();
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (out_valid !== 1'b1 || pc_out !== 32'(i * 4) || {instr_out, pc_out, pc8_out} !== exp_head()) begin
        n_fail++; $display("FAIL drain_%0d: got valid=%b head=%h expected valid=1 head=%h", i, out_valid, {instr_out, pc_out, pc8_out}, exp_head());
      end
      if (i == 0) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_full_ready: got %b expected 0", in_ready); end
      end
      if (i == 1) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_rise: got %b expected 1", in_ready); end
      end
      advance();
      #3;
    end
    ordy = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL drain_empty: got valid=%b count=%0d expected valid=0 count=0", out_valid, count); end
    @(posedge clock); #1;
  endtask

  task automatic test_simul();
    ordy = 1'b0;
    for (int i = 0; i < 2; i++) begin set_in(1'b1, 32'h200 + 32'(i * 4)); advance(); end
    for (int i = 0; i < 10; i++) begin
      ordy = 1'b1;
      set_in(1'b1, 32'h300 + 32'(i * 4));
      #4;
      n_tests++; if (count !== CW'(2) || {instr_out, pc_out, pc8_out} !== exp_head()) begin
        n_fail++; $display("FAIL simul_%0d: got count=%0d head=%h expected count=2 head=%h", i, count, {instr_out, pc_out, pc8_out}, exp_head());
      end
      advance();
    end
    set_in(1'b0, '0);
    ordy = 1'b0;
    #4;
    n_tests++; if (count !== CW'(2) || pc_out !== 32'h320) begin n_fail++; $display("FAIL simul_final: got count=%0d pc=%h expected count=2 pc=320", count, pc_out); end
    @(posedge clock); #1;
  endtask

  task automatic test_flush();
    ordy = 1'b0;
    set_in(1'b1, 32'h400); advance();
    set_in(1'b1, 32'h500); ordy = 1'b1; fl = 1'b1;
    #4;
    n_tests++; if (count !== CW'(3) || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_during: got count=%0d valid=%b ready=%b expected 3 0 0", count, out_valid, in_ready);
    end
    advance();
    fl = 1'b0; ordy = 1'b0; set_in(1'b0, '0);
    #4;
    n_tests++; if (count !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got count=%0d valid=%b expected 0 0", count, out_valid); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    ordy = 1'b0;
    for (int i = 0; i < 2; i++) begin set_in(1'b1, 32'h600 + 32'(i * 4)); advance(); end
    set_in(1'b0, '0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    n_tests++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || pc_out !== '0 || instr_out !== '0) begin
      n_fail++; $display("FAIL reset_mid: got count=%0d valid=%b ready=%b pc=%h expected all 0", count, out_valid, in_ready, pc_out);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    set_in(1'b1, 32'h100);
    #4;
    n_tests++; if (out_valid !== BYP || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_push: got valid=%b ready=%b expected valid=%b ready=1", out_valid, in_ready, BYP); end
    advance();
    set_in(1'b0, '0);
    #4;
    n_tests++; if (out_valid !== 1'b1 || pc_out !== 32'h100) begin n_fail++; $display("FAIL reset_mid_head: got valid=%b pc=%h expected 1 100", out_valid, pc_out); end
    ordy = 1'b1;
    advance();
    ordy = 1'b0;
  endtask

  task automatic test_bypass();
    ordy = 1'b1;
    set_in(1'b1, 32'h40);
    #4;
    n_tests++; if (out_valid !== BYP || pc_out !== (BYP ? 32'h40 : 32'h0) || count !== '0) begin
      n_fail++; $display("FAIL bypass_same: got valid=%b pc=%h count=%0d expected valid=%b", out_valid, pc_out, count, BYP);
    end
    advance();
    set_in(1'b0, '0);
    ordy = 1'b0;
    #4;
    n_tests++; if (out_valid !== !BYP || count !== CW'(BYP ? 0 : 1) || pc_out !== (BYP ? 32'h0 : 32'h40)) begin
      n_fail++; $display("FAIL bypass_next: got valid=%b pc=%h count=%0d expected valid=%b", out_valid, pc_out, count, !BYP);
    end
    fl = 1'b1;
    advance();
    fl = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom);
      ordy = $urandom_range(0, 1);
      fl   = ($urandom_range(0, 15) == 0);
      #4;
      n_tests++; if (in_ready !== exp_in_ready() || out_valid !== exp_out_valid() || count !== CW'(exp_q.size()) || {instr_out, pc_out, pc8_out} !== exp_head()) begin
        n_fail++; $display("FAIL random_%0d: got ready=%b valid=%b count=%0d head=%h expected ready=%b valid=%b count=%0d head=%h",
          i, in_ready, out_valid, count, {instr_out, pc_out, pc8_out}, exp_in_ready(), exp_out_valid(), exp_q.size(), exp_head());
      end
      advance();
    end
    set_in(1'b0, '0); ordy = 1'b0; fl = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_flush();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the instruction/PC word width.
REQ-003 The block SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 The block SHALL have port InstrIn  input  WIDTH  instruction word from the fetch stage.
REQ-006 The block SHALL have port PCIn  input  WIDTH  PC of InstrIn.
REQ-007 The block SHALL have port PCPlus8In  input  WIDTH  PCPlus8 value accompanying InstrIn.
REQ-008 The block SHALL have port InValid  input  1  fetch stage offers an entry.
REQ-009 The block SHALL have port InReady  output  1  queue accepts an entry this cycle.
REQ-010 The block SHALL have port InstrOut, PCOut, PCPlus8Out  output  WIDTH each  head entry presented to decode.
REQ-011 The block SHALL have port OutValid  output  1  head entry valid.
REQ-012 The block SHALL have port OutReady  input  1  decode consumes the head this cycle.
REQ-013 The block SHALL have port Flush  input  1  discard all entries (branch taken / PCSelector redirect).
REQ-014 The block SHALL have port Count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-015 Push SHALL occur on a rising edge when InValid && InReady; the entry is written at the write pointer, which then increments modulo DEPTH.
REQ-016 Pop SHALL occur on a rising edge when OutValid && OutReady && the head comes from storage; the read pointer then increments modulo DEPTH.
REQ-017 InReady SHALL equal (Count != DEPTH) && !Flush and SHALL NOT depend on OutReady.
REQ-018 OutValid SHALL equal (Count != 0) && !Flush, except as extended by REQ-029.
REQ-019 Head outputs SHALL be a combinational read of the entry at the read pointer; when Count == 0 they SHALL be 0, except as extended by REQ-029.
REQ-020 Count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop or on neither.
REQ-021 Minimum latency from push to OutValid SHALL be 1 cycle.
REQ-022 When full, a simultaneous OutReady pop SHALL still occur; no push SHALL occur in that cycle, and InReady SHALL rise on the next cycle.
REQ-023 When Flush is 1 at an edge, both pointers and Count SHALL clear to 0; any concurrent push or pop SHALL be discarded; storage contents need not clear.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.
REQ-025 Entries SHALL never be dropped or duplicated except by Flush or reset.

Reset
REQ-026 While reset is 0, pointers, Count, and all storage entries SHALL be 0, asynchronously.
REQ-027 During reset, InReady=0, OutValid=0, and all head outputs SHALL be 0; InReady SHALL be 1 on the first cycle after reset deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, regardless of Flush or the handshakes.

Configuration
REQ-029 With macro FETCH_QUEUE_BYPASS_EN defined, when Count == 0 && InValid && !Flush, OutValid SHALL be 1 and the head outputs SHALL equal the inputs combinationally. If OutReady is also 1, the entry SHALL pass through with zero latency, without being written and without changing Count. If OutReady is 0, it SHALL be pushed normally.
REQ-030 Without FETCH_QUEUE_BYPASS_EN, REQ-018, REQ-019 and REQ-021 SHALL apply unmodified (1-cycle minimum latency).

Verification
REQ-031 After reset, push PCIn=0x00,0x04,0x08,0x0C with OutReady=0 -> Count=4, InReady=0; a fifth InValid SHALL be ignored.
REQ-032 With the queue full, assert OutReady=1 for 4 cycles -> PCOut sequence 0x00,0x04,0x08,0x0C, then OutValid=0 and Count=0.
REQ-033 With Count=2, push and pop in the same cycle -> Count stays 2 and head advances to the second entry; run 10 such cycles to cover pointer wrap.
REQ-034 With Count=3, assert Flush together with InValid and OutReady -> next cycle Count=0, OutValid=0, and the pushed entry is absent.
REQ-035 Assert reset (0) with Count=2 mid-cycle -> outputs go to 0 immediately; after release, push 0x100 -> OutValid=1 one cycle later with PCOut=0x100.
REQ-036 With FETCH_QUEUE_BYPASS_EN, empty queue, InValid=1, OutReady=1, PCIn=0x40 -> same-cycle OutValid=1, PCOut=0x40, and Count remains 0; without the macro, OutValid=0 that cycle and 1 the next.
